calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Top-level control stage of the calculator; sits upstream of the operand/display handler.
- Synchronises and edge-detects the raw confirm push-button and drives the 3-bit state code and one-cycle load strobe that the handler consumes.
- Reads back the handler's latched operands, computes a saturated 6-bit signed result for the selected operation (add/sub/mul single-cycle, divide iterative), and presents it with status flags.

Parameters:
- DIV_STEPS, 6, quotient bits resolved per divide (one per cycle); must equal operand width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- confirm_btn  input  1  raw asynchronous push-button, high = pressed
- op_select  input  2  operation: 00 add, 01 sub (op1-op2), 10 mul, 11 div
- operand1  input  6  signed operand A from handler
- operand2  input  6  signed operand B from handler
- state  output  3  sequencer state code to handler
- confirm  output  1  one-cycle load strobe to handler
- result  output  6  signed saturated result
- result_valid  output  1  high while state==RESULT
- overflow  output  1  true result outside -32..31; result saturated
- div_by_zero  output  1  divide with operand2==0
- busy  output  1  high while state==COMPUTE

Behaviour:
- Reset (sync, active-high), required at the next clk edge with reset high: state=000, confirm=0, result=0, result_valid=0, overflow=0, div_by_zero=0, busy=0; sync flops, edge register, divider datapath and captured op cleared. Reset mid-divide aborts with no result update.
- Button path: sync1<=confirm_btn; sync2<=sync1; prev<=sync2; press = sync2 & ~prev (combinational). One press per rising edge, however long held. Button sampled high at edge k -> press high in cycle after edge k+1 -> FSM moves at edge k+2.
- States (encoding = state output):
  - 000 IDLE: press -> 001.
  - 001 ENTER1: handler shows raw input; press -> 010.
  - 010 LATCH1: exactly 1 cycle; confirm=1; -> 011 unconditionally.
  - 011 ENTER2: press -> 100.
  - 100 LATCH2: exactly 1 cycle; confirm=1; -> 101.
  - 101 SELECT: press -> 110; capture op_select, operand1, operand2 on that edge.
  - 110 COMPUTE: busy=1; duration below; -> 111.
  - 111 RESULT: result_valid=1; press -> 001 (new calculation, operands re-entered).
- confirm = (state==010)|(state==100), registered-state decode, never high elsewhere.
- Presses in 010, 100, 110 are dropped (not queued).
- Arithmetic on captured A, B (6-bit signed, -32..31):
  - add/sub: 7-bit exact sum/difference; mul: 12-bit exact product.
  - Saturate to 6 bits: >31 -> 31, <-32 -> -32, overflow=1; else overflow=0.
  - COMPUTE lasts exactly 1 cycle for add, sub, mul.
- Divide, truncating toward zero: quotient = A/B.
  - B==0: result=0, div_by_zero=1, overflow=0; COMPUTE lasts 1 cycle.
  - Else restoring division on |A|, |B|, one quotient bit per cycle for DIV_STEPS cycles, then 1 sign-fixup/saturation cycle; COMPUTE lasts DIV_STEPS+1 = 7 cycles.
  - -32/-1 = +32 -> result 31, overflow=1. Remainder discarded.
- result, overflow, div_by_zero update only on the edge leaving COMPUTE and hold until the next COMPUTE completion or reset. div_by_zero=0 for non-divide ops.
- op_select and operand changes during COMPUTE have no effect.

Test Plan:
- Reset, hold confirm_btn high 50 cycles -> exactly one transition 000->001; all outputs 0 after reset.
- Full walk with A=7, B=5, op 00 -> confirm high exactly during states 010 and 100; COMPUTE 1 cycle; result=12, overflow=0, result_valid=1 in 111.
- A=3, B=9, op 01 -> result=-6 (6'b111010); A=15, B=15, op 10 -> result=31, overflow=1.
- A=15, B=4, op 11 -> busy high exactly 7 cycles; result=3. A=-13, B=4 -> result=-3. A=-32, B=-1 -> result=31, overflow=1.
- A=9, B=0, op 11 -> COMPUTE 1 cycle; result=0, div_by_zero=1. Next calc with op 00 -> div_by_zero=0.
- Press during COMPUTE of a divide -> ignored, FSM still reaches 111. Reset asserted at divide cycle 3 -> state=000 and all outputs 0 at next edge.

Source files
------------

// File: rtl/calc_sequencer.sv
// Calculator control stage: button sync/edge-detect, state sequencing,
// and saturated add/sub/mul/div on the captured operands.
module calc_sequencer #(
  parameter int DIV_STEPS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       confirm_btn,
  input  logic [1:0] op_select,
  input  logic [5:0] operand1,
  input  logic [5:0] operand2,
  output logic [2:0] state,
  output logic       confirm,
  output logic [5:0] result,
  output logic       result_valid,
  output logic       overflow,
  output logic       div_by_zero,
  output logic       busy
);

  localparam int W  = DIV_STEPS;
  localparam int CW = $clog2(DIV_STEPS + 1);
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic signed [2*W-1:0] MAXV = (2*W)'(2**(W-1) - 1);
  localparam logic signed [2*W-1:0] MINV = -(2*W)'(2**(W-1));

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_ENTER1  = 3'b001,
    S_LATCH1  = 3'b010,
    S_ENTER2  = 3'b011,
    S_LATCH2  = 3'b100,
    S_SELECT  = 3'b101,
    S_COMPUTE = 3'b110,
    S_RESULT  = 3'b111
  } state_t;

  state_t r_state, w_next;

  logic r_sync1, r_sync2, r_prev;
  logic w_press;

  logic [1:0]    r_op;
  logic [W-1:0]  r_a, r_b;
  logic [W-1:0]  r_rem, r_quo, r_dvs;
  logic          r_neg;
  logic [CW-1:0] r_cnt;

  logic          w_capture, w_bzero, w_done, w_step;
  logic [W:0]    w_shift, w_diff;
  logic          w_fits;
  logic [W-1:0]  w_mag_a, w_mag_b;

  logic signed [2*W-1:0] w_sa, w_sb, w_q, w_wide;
  logic                  w_ovf;
  logic [W-1:0]          w_sat;

  assign w_press = r_sync2 & ~r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= confirm_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_press) w_next = S_ENTER1;
      S_ENTER1:  if (w_press) w_next = S_LATCH1;
      S_LATCH1:  w_next = S_ENTER2;
      S_ENTER2:  if (w_press) w_next = S_LATCH2;
      S_LATCH2:  w_next = S_SELECT;
      S_SELECT:  if (w_press) w_next = S_COMPUTE;
      S_COMPUTE: if (w_done)  w_next = S_RESULT;
      S_RESULT:  if (w_press) w_next = S_ENTER1;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    confirm      = (r_state == S_LATCH1) | (r_state == S_LATCH2);
    busy         = (r_state == S_COMPUTE);
    result_valid = (r_state == S_RESULT);
  end

  assign state = r_state;

  assign w_capture = (r_state == S_SELECT) & w_press;
  assign w_bzero   = (r_b == '0);
  assign w_done    = busy & ((r_op != OP_DIV) | w_bzero |
                             (r_cnt == CW'(W)));
  assign w_step    = busy & (r_cnt != CW'(W));

  assign w_mag_a = operand1[W-1] ? -operand1 : operand1;
  assign w_mag_b = operand2[W-1] ? -operand2 : operand2;

  // Restoring step: remainder stays below divisor, so W bits suffice.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
    end else if (w_capture) begin
      r_op  <= op_select;
      r_a   <= operand1;
      r_b   <= operand2;
      r_rem <= '0;
      r_quo <= w_mag_a;
      r_dvs <= w_mag_b;
      r_neg <= operand1[W-1] ^ operand2[W-1];
      r_cnt <= '0;
    end else if (w_step) begin
      r_rem <= W'(w_fits ? w_diff : w_shift);
      r_quo <= {r_quo[W-2:0], w_fits};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_sa = {{W{r_a[W-1]}}, r_a};
  assign w_sb = {{W{r_b[W-1]}}, r_b};
  assign w_q  = {{W{1'b0}}, r_quo};

  always_comb begin
    w_wide = '0;
    unique case (r_op)
      2'b00:   w_wide = w_sa + w_sb;
      2'b01:   w_wide = w_sa - w_sb;
      2'b10:   w_wide = w_sa * w_sb;
      default: w_wide = r_neg ? -w_q : w_q;
    endcase
  end

  assign w_ovf = (w_wide > MAXV) | (w_wide < MINV);
  assign w_sat = !w_ovf       ? w_wide[W-1:0] :
                 w_wide[2*W-1] ? {1'b1, {(W-1){1'b0}}} :
                                 {1'b0, {(W-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (w_done) begin
      if ((r_op == OP_DIV) && w_bzero) begin
        result      <= '0;
        overflow    <= 1'b0;
        div_by_zero <= 1'b1;
      end else begin
        result      <= w_sat;
        overflow    <= w_ovf;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: directed calculations,
// a monitor checks each RESULT entry against queued expectations.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       confirm_btn = 1'b0;
  logic [1:0] op_select = 2'b00;
  logic [5:0] operand1 = '0;
  logic [5:0] operand2 = '0;
  logic [2:0] state;
  logic       confirm;
  logic [5:0] result;
  logic       result_valid;
  logic       overflow;
  logic       div_by_zero;
  logic       busy;

  calc_sequencer #(.DIV_STEPS(6)) dut (
    .clk(clk),
    .reset(reset),
    .confirm_btn(confirm_btn),
    .op_select(op_select),
    .operand1(operand1),
    .operand2(operand2),
    .state(state),
    .confirm(confirm),
    .result(result),
    .result_valid(result_valid),
    .overflow(overflow),
    .div_by_zero(div_by_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    res;
    int    ovf;
    int    dbz;
    int    nbusy;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, state=%0d", nm, state);
  endtask

  task automatic wait_state(int tgt, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(state) == tgt) return;
    end
    timeout($sformatf("wait_state%0d", tgt));
  endtask

  task automatic press_to(int tgt, int budget);
    confirm_btn = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i == 1) confirm_btn = 1'b0;
      if (int'(state) == tgt) begin
        confirm_btn = 1'b0;
        return;
      end
    end
    confirm_btn = 1'b0;
    timeout($sformatf("press_to%0d", tgt));
  endtask

  task automatic enter(int a, int b, logic [1:0] op);
    if (state != 3'd1) press_to(1, 12);
    operand1 = 6'(a);
    press_to(3, 12);
    operand2 = 6'(b);
    press_to(5, 12);
    op_select = op;
  endtask

  task automatic calc(string nm, int a, int b, logic [1:0] op,
                      int er, int eo, int ed, int eb, bit poke);
    exp_t e;
    enter(a, b, op);
    e = '{nm: nm, res: er, ovf: eo, dbz: ed, nbusy: eb};
    sb.push_back(e);
    press_to(6, 12);
    operand1  = 6'($urandom);
    operand2  = 6'($urandom);
    op_select = ~op;
    if (poke) begin
      confirm_btn = 1'b1;
      @(negedge clk);
      confirm_btn = 1'b0;
    end
    wait_state(7, 20);
    if (poke) begin
      repeat (6) @(negedge clk);
      chk({nm, ".drop"}, int'(state), 7);
    end
  endtask

  // Monitor: pops one expectation each time RESULT is entered.
  initial begin
    int  n_busy = 0;
    int  n_conf = 0;
    bit  prev_rv = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_busy  = 0;
        n_conf  = 0;
        prev_rv = 1'b0;
      end else begin
        if (busy) n_busy++;
        if (confirm) n_conf++;
        if (result_valid && !prev_rv) begin
          if (sb.size() == 0) begin
            timeout("unexpected_result");
          end else begin
            e = sb.pop_front();
            chk({e.nm, ".result"}, $signed(result), e.res);
            chk({e.nm, ".overflow"}, int'(overflow), e.ovf);
            chk({e.nm, ".div_by_zero"}, int'(div_by_zero), e.dbz);
            chk({e.nm, ".busy_cycles"}, n_busy, e.nbusy);
            chk({e.nm, ".confirm_cycles"}, n_conf, 2);
          end
          n_busy = 0;
          n_conf = 0;
        end
        prev_rv = result_valid;
      end
    end
  end

  initial begin
    int    trans;
    logic [2:0] ps;

    repeat (3) @(negedge clk);
    chk("rst.state", int'(state), 0);
    chk("rst.result", int'(result), 0);
    chk("rst.flags", int'({confirm, result_valid, overflow,
                           div_by_zero, busy}), 0);
    reset = 1'b0;

    // Held button: exactly one IDLE->ENTER1 transition.
    trans = 0;
    ps = state;
    confirm_btn = 1'b1;
    for (int i = 0; i < 54; i++) begin
      @(negedge clk);
      if (i == 49) confirm_btn = 1'b0;
      if (state != ps) trans++;
      ps = state;
    end
    chk("hold.transitions", trans, 1);
    chk("hold.state", int'(state), 1);

    calc("add7p5",    7,   5, 2'b00,  12, 0, 0, 1, 1'b0);
    calc("sub3m9",    3,   9, 2'b01,  -6, 0, 0, 1, 1'b0);
    calc("mul15x15", 15,  15, 2'b10,  31, 1, 0, 1, 1'b0);
    calc("div15d4",  15,   4, 2'b11,   3, 0, 0, 7, 1'b0);
    calc("divm13d4", -13,  4, 2'b11,  -3, 0, 0, 7, 1'b0);
    calc("divm32dm1", -32, -1, 2'b11, 31, 1, 0, 7, 1'b0);
    calc("div9d0",    9,   0, 2'b11,   0, 0, 1, 1, 1'b0);
    calc("addm20",  -20, -20, 2'b00, -32, 1, 0, 1, 1'b0);
    calc("divm31d5", -31,  5, 2'b11,  -6, 0, 0, 7, 1'b1);

    // Reset in the third divide cycle aborts the calculation.
    enter(27, 3, 2'b11);
    press_to(6, 12);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.state", int'(state), 0);
    chk("abort.result", int'(result), 0);
    chk("abort.flags", int'({confirm, result_valid, overflow,
                             div_by_zero, busy}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    calc("add1p2",    1,   2, 2'b00,   3, 0, 0, 1, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb.empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
